xpb_rom_accum: RTL and testbench
================================

Name: xpb_rom_accum

Overview:
- Parametrised successor to the fixed 5-bit xpb lookup tables.
- Holds NUM_TABLES runtime-loadable tables, each 2^IDX_BITS x WORD_BITS, instead of hard-coded constants.
- Takes one packed digit vector per transaction, looks up one entry per table sequentially, and returns the exact integer sum of all lookups.
- Sits between the upper-digit split of the squarer output and the modular reduction adder tree, replacing a bank of per-digit xpb ROMs plus their adders.

Parameters:
- WORD_BITS, 1024, width of each table entry.
- IDX_BITS, 5, digit width; each table has 2^IDX_BITS entries.
- NUM_TABLES, 8, number of digits and tables per transaction (>=1).
- ACC_BITS, WORD_BITS+$clog2(NUM_TABLES), accumulator/output width (derived, not overridden).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- tbl_wr_en  in  1  table write strobe
- tbl_wr_ready  out  1  table write accepted this cycle (high only in IDLE)
- tbl_wr_sel  in  $clog2(NUM_TABLES) (min 1)  target table
- tbl_wr_idx  in  IDX_BITS  target entry
- tbl_wr_data  in  WORD_BITS  entry value
- in_valid  in  1  digit vector valid
- in_ready  out  1  block can accept a digit vector
- in_digits  in  NUM_TABLES*IDX_BITS  digit t at bits [t*IDX_BITS +: IDX_BITS]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  ACC_BITS  sum over t of table[t][digit t]

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values:
  - Block enters IDLE.
  - in_ready=1, tbl_wr_ready=1, out_valid=0, out_sum=0.
  - Table contents are NOT cleared by reset.
- Entry 0 of every table reads as zero; writes with tbl_wr_idx=0 are dropped. This matches the xpb convention.
- Table write: occurs when tbl_wr_en&tbl_wr_ready; storage updates at the clock edge.
  - tbl_wr_en outside IDLE is ignored (no queuing).
  - Write and input handshake in the same IDLE cycle: the write completes before the first lookup, so it is visible to that transaction.
- FSM states:
  - IDLE: in_ready=1. On in_valid: latch in_digits, clear accumulator, k=0, go to RUN.
  - RUN: each cycle issue a registered read of table k at latched digit k, then k++. After issuing k=NUM_TABLES-1, go to DRAIN.
  - DRAIN: one cycle for the final read data to be accumulated, then go to HOLD.
  - HOLD: out_valid=1, out_sum stable. On out_ready, go to IDLE.
- Read pipeline: read data arrives one cycle after issue and is added to the accumulator that cycle.
- Latency: input handshake in cycle C gives out_valid=1 from cycle C+NUM_TABLES+2. Throughput is one transaction per NUM_TABLES+3 cycles.
- out_sum holds its value after HOLD until the next transaction clears the accumulator; consumers must only sample it under out_valid.
- Arithmetic: unsigned, no modular reduction, no truncation. ACC_BITS guarantees NUM_TABLES*(2^WORD_BITS-1) fits.
- out_valid is held while out_ready=0 (backpressure); in_ready stays 0 meanwhile.
- Reset mid-RUN/DRAIN/HOLD: the transaction is discarded, the next cycle shows IDLE reset values, and no out_valid pulse is produced.

Decomposition:
- Package xpb_pkg: the FSM state enum (IDLE, RUN, DRAIN, HOLD) and helper functions for ACC_BITS and select width.
- One sub-module, xpb_table_ram: a single table with a write port and a registered read port, entry-0 forcing included.
  - Instantiated NUM_TABLES times with a shared read index.
  - Read data is muxed by k delayed by one cycle.

Test Plan:
- Use WORD_BITS=16, IDX_BITS=2, NUM_TABLES=3 (ACC_BITS=18) for all scenarios.
- Basic sum: load table[t][i]=(t+1)*0x100+i for i=1..3. Send digits t0=3, t1=1, t2=2 in cycle C -> out_valid at C+5, out_sum=0x00606.
- Zero digit and overflow: set all entries to 0xFFFF, write idx0=0x1234 (dropped).
  - Digits 3,3,3 -> out_sum=0x2FFFD.
  - Digits 0,3,0 -> out_sum=0x0FFFF.
- Backpressure: hold out_ready=0 for 4 cycles in HOLD -> out_sum stable, in_ready=0, then one-cycle return to IDLE. Back-to-back in_valid is accepted the cycle after the out handshake.
- Write blocking: tbl_wr_en during RUN with new data -> tbl_wr_ready=0, and a rerun of the same digits gives an unchanged sum. A write in the same IDLE cycle as the input handshake is used by that transaction.
- Reset mid-RUN: assert reset in cycle C+2 -> next cycle in_ready=1, out_valid=0, out_sum=0. Tables are retained; a rerun of the basic vector gives 0x00606.

Source files
------------

// File: rtl/xpb_pkg.sv
// Shared definitions for the xpb digit-lookup accumulator: FSM states and
// width helpers for the table select and the result accumulator.
package xpb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } xpb_state_e;

  // A single table still needs a one-bit select so the port is never zero width.
  function automatic int sel_bits(input int num_tables);
    return (num_tables > 1) ? $clog2(num_tables) : 1;
  endfunction

  function automatic int acc_bits(input int word_bits, input int num_tables);
    return word_bits + $clog2(num_tables);
  endfunction

endpackage

// File: rtl/xpb_rom_accum_if.sv
// Table-load, digit-input and result handshakes of xpb_rom_accum, bundled
// with a master (producer/consumer side) and slave (block side) view.
interface xpb_rom_accum_if
  import xpb_pkg::*;
#(
  parameter int WORD_BITS  = 1024,
  parameter int IDX_BITS   = 5,
  parameter int NUM_TABLES = 8
);
  localparam int SEL_W = sel_bits(NUM_TABLES);
  localparam int ACC_W = acc_bits(WORD_BITS, NUM_TABLES);

  logic                           tbl_wr_en;
  logic                           tbl_wr_ready;
  logic [SEL_W-1:0]               tbl_wr_sel;
  logic [IDX_BITS-1:0]            tbl_wr_idx;
  logic [WORD_BITS-1:0]           tbl_wr_data;
  logic                           in_valid;
  logic                           in_ready;
  logic [NUM_TABLES*IDX_BITS-1:0] in_digits;
  logic                           out_valid;
  logic                           out_ready;
  logic [ACC_W-1:0]               out_sum;

  modport master (
    output tbl_wr_en, tbl_wr_sel, tbl_wr_idx, tbl_wr_data,
    output in_valid, in_digits, out_ready,
    input  tbl_wr_ready, in_ready, out_valid, out_sum
  );

  modport slave (
    input  tbl_wr_en, tbl_wr_sel, tbl_wr_idx, tbl_wr_data,
    input  in_valid, in_digits, out_ready,
    output tbl_wr_ready, in_ready, out_valid, out_sum
  );

endinterface

// File: rtl/xpb_table_ram.sv
// One runtime-loadable xpb table with a registered read port; entry 0 is
// hard-wired to zero and never stored.
module xpb_table_ram #(
  parameter int WORD_BITS = 1024,
  parameter int IDX_BITS  = 5
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [IDX_BITS-1:0]  wr_idx,
  input  logic [WORD_BITS-1:0] wr_data,
  input  logic [IDX_BITS-1:0]  rd_idx,
  output logic [WORD_BITS-1:0] rd_data
);
  localparam int DEPTH = 1 << IDX_BITS;

  logic [WORD_BITS-1:0] mem_q [DEPTH];
  logic [WORD_BITS-1:0] rd_data_d;
  logic [WORD_BITS-1:0] rd_data_q;

  always_comb begin
    rd_data_d = (rd_idx == '0) ? '0 : mem_q[rd_idx];
  end

  // Storage is deliberately not reset: loaded tables survive a block reset.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_idx != '0)) begin
      mem_q[wr_idx] <= wr_data;
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/xpb_rom_accum.sv
// Sums one lookup per table for a packed digit vector, issuing one table read
// per cycle and accumulating the registered read data one cycle later.
module xpb_rom_accum
  import xpb_pkg::*;
#(
  parameter int WORD_BITS  = 1024,
  parameter int IDX_BITS   = 5,
  parameter int NUM_TABLES = 8
) (
  input  logic            clk,
  input  logic            reset,
  xpb_rom_accum_if.slave  bus
);
  localparam int SEL_W    = sel_bits(NUM_TABLES);
  localparam int ACC_BITS = acc_bits(WORD_BITS, NUM_TABLES);

  xpb_state_e                     state_q, state_d;
  logic [SEL_W-1:0]               k_q, k_d;
  logic [SEL_W-1:0]               k_p1_q;
  logic [NUM_TABLES*IDX_BITS-1:0] digits_q, digits_d;
  logic [ACC_BITS-1:0]            acc_q, acc_d;
  logic                           vld_p0;
  logic                           vld_p1_q;
  logic [IDX_BITS-1:0]            rd_idx_p0;
  logic [WORD_BITS-1:0]           rd_data_p1 [NUM_TABLES];
  logic [WORD_BITS-1:0]           rd_sel_p1;
  logic                           wr_go;

  assign wr_go = bus.tbl_wr_en && bus.tbl_wr_ready;

  for (genvar t = 0; t < NUM_TABLES; t++) begin : g_tbl
    xpb_table_ram #(
      .WORD_BITS (WORD_BITS),
      .IDX_BITS  (IDX_BITS)
    ) u_tbl (
      .clk     (clk),
      .wr_en   (wr_go && (bus.tbl_wr_sel == SEL_W'(t))),
      .wr_idx  (bus.tbl_wr_idx),
      .wr_data (bus.tbl_wr_data),
      .rd_idx  (rd_idx_p0),
      .rd_data (rd_data_p1[t])
    );
  end

  // Stage p0: pick the latched digit for the table being issued this cycle.
  always_comb begin
    rd_idx_p0 = '0;
    for (int t = 0; t < NUM_TABLES; t++) begin
      if (k_q == SEL_W'(t)) rd_idx_p0 = digits_q[t*IDX_BITS +: IDX_BITS];
    end
  end

  // Stage p1: read data is steered by the table index issued one cycle ago.
  always_comb begin
    rd_sel_p1 = '0;
    for (int t = 0; t < NUM_TABLES; t++) begin
      if (k_p1_q == SEL_W'(t)) rd_sel_p1 = rd_data_p1[t];
    end
  end

  always_comb begin
    state_d          = state_q;
    k_d              = k_q;
    digits_d         = digits_q;
    acc_d            = acc_q;
    vld_p0           = 1'b0;
    bus.in_ready     = 1'b0;
    bus.tbl_wr_ready = 1'b0;
    bus.out_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready     = 1'b1;
        bus.tbl_wr_ready = 1'b1;
        if (bus.in_valid) begin
          digits_d = bus.in_digits;
          acc_d    = '0;
          k_d      = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        vld_p0 = 1'b1;
        k_d    = k_q + SEL_W'(1);
        if (k_q == SEL_W'(NUM_TABLES - 1)) state_d = DRAIN;
      end
      DRAIN: state_d = HOLD;
      HOLD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (vld_p1_q) acc_d = acc_q + ACC_BITS'(rd_sel_p1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      vld_p1_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      vld_p1_q <= vld_p0;
      acc_q    <= acc_d;
    end
  end

  always_ff @(posedge clk) begin
    digits_q <= digits_d;
    k_p1_q   <= k_q;
  end

  assign bus.out_sum = acc_q;

endmodule

// File: tb/tb_xpb_rom_accum.sv
// Directed bench for xpb_rom_accum with WORD_BITS=16, IDX_BITS=2, NUM_TABLES=3.
module tb_xpb_rom_accum;
  localparam int WB = 16;
  localparam int IB = 2;
  localparam int NT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  xpb_rom_accum_if #(.WORD_BITS(WB), .IDX_BITS(IB), .NUM_TABLES(NT)) bus ();

  xpb_rom_accum #(.WORD_BITS(WB), .IDX_BITS(IB), .NUM_TABLES(NT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int sel, input int idx, input logic [15:0] data);
    bus.tbl_wr_en   = 1'b1;
    bus.tbl_wr_sel  = 2'(sel);
    bus.tbl_wr_idx  = 2'(idx);
    bus.tbl_wr_data = data;
    tick();
    bus.tbl_wr_en = 1'b0;
  endtask

  // Drive one digit vector {d2,d1,d0}; returns in cycle C+1.
  task automatic start(input string tag, input int d0, input int d1, input int d2);
    bus.in_digits = {2'(d2), 2'(d1), 2'(d0)};
    bus.in_valid  = 1'b1;
    check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Wait for the result (lat0 = current cycle offset from the handshake),
  // apply `hold` cycles of backpressure, then complete the output handshake.
  task automatic wait_result(input string tag, input int lat0, input logic [31:0] exp, input int hold);
    int lat;
    logic [31:0] first;
    lat = lat0;
    while (!bus.out_valid && lat < 30) begin
      tick();
      lat++;
    end
    check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, "_latency"}, 32'(lat), 32'd5);
    check_eq({tag, "_sum"}, 32'(bus.out_sum), exp);
    first = 32'(bus.out_sum);
    for (int i = 0; i < hold; i++) begin
      tick();
      check_eq({tag, "_bp_valid"}, 32'(bus.out_valid), 32'd1);
      check_eq({tag, "_bp_in_ready"}, 32'(bus.in_ready), 32'd0);
      check_eq({tag, "_bp_sum"}, 32'(bus.out_sum), first);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_eq({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, "_idle_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_vec(input string tag, input int d0, input int d1, input int d2,
                         input logic [31:0] exp, input int hold);
    start(tag, d0, d1, d2);
    wait_result(tag, 1, exp, hold);
  endtask

  initial begin
    int pulses;
    bus.tbl_wr_en   = 1'b0;
    bus.tbl_wr_sel  = '0;
    bus.tbl_wr_idx  = '0;
    bus.tbl_wr_data = '0;
    bus.in_valid    = 1'b0;
    bus.in_digits   = '0;
    bus.out_ready   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_wr_ready", 32'(bus.tbl_wr_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_sum", 32'(bus.out_sum), 32'd0);

    // table[t][i] = (t+1)*0x100 + i
    for (int t = 0; t < NT; t++)
      for (int i = 1; i < 4; i++)
        write_entry(t, i, 16'((t + 1) * 256 + i));

    // 0x103 + 0x201 + 0x302
    run_vec("basic", 3, 1, 2, 32'h00606, 0);
    // backpressure, then back-to-back acceptance right after the out handshake
    run_vec("bp", 3, 1, 2, 32'h00606, 4);
    run_vec("b2b", 1, 2, 3, 32'h00606, 0);

    // Write attempted during RUN must be refused and have no effect.
    start("wblk", 3, 1, 2);
    bus.tbl_wr_en   = 1'b1;
    bus.tbl_wr_sel  = 2'd0;
    bus.tbl_wr_idx  = 2'd3;
    bus.tbl_wr_data = 16'hAAAA;
    check_eq("wblk_wr_ready", 32'(bus.tbl_wr_ready), 32'd0);
    tick();
    bus.tbl_wr_en = 1'b0;
    wait_result("wblk", 2, 32'h00606, 0);
    run_vec("wblk_rerun", 3, 1, 2, 32'h00606, 0);

    // Write in the handshake cycle is seen by that transaction: 0x500+0x201+0x302.
    bus.tbl_wr_en   = 1'b1;
    bus.tbl_wr_sel  = 2'd0;
    bus.tbl_wr_idx  = 2'd3;
    bus.tbl_wr_data = 16'h0500;
    start("wsame", 3, 1, 2);
    bus.tbl_wr_en = 1'b0;
    wait_result("wsame", 1, 32'h00A03, 0);
    write_entry(0, 3, 16'h0103);

    // Reset asserted in cycle C+2 of a transaction.
    start("rmid", 3, 1, 2);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rmid_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rmid_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rmid_out_sum", 32'(bus.out_sum), 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) pulses++;
      tick();
    end
    check_eq("rmid_no_pulse", 32'(pulses), 32'd0);
    run_vec("rmid_rerun", 3, 1, 2, 32'h00606, 0);

    // Saturated tables; idx 0 write must be dropped.
    for (int t = 0; t < NT; t++)
      for (int i = 1; i < 4; i++)
        write_entry(t, i, 16'hFFFF);
    write_entry(1, 0, 16'h1234);
    run_vec("ovf", 3, 3, 3, 32'h2FFFD, 0);
    run_vec("zero_dig", 0, 3, 0, 32'h0FFFF, 0);
    run_vec("all_zero", 0, 0, 0, 32'h00000, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
